// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - front-end/account-store signal bundle for atm_session_ctrl
// master = card/keypad front end and account store, slave = session controller.
interface atm_session_ctrl_if #(
  parameter int CARD_W = 8,
  parameter int PIN_W  = 4,
  parameter int BAL_W  = 8,
  parameter int AMT_W  = 5
);
  logic              card_valid;
  logic [CARD_W-1:0] cardno;
  logic [1:0]        language;
  logic [PIN_W-1:0]  correctPin;
  logic [BAL_W-1:0]  currentbalance;
  logic              pin_valid;
  logic [PIN_W-1:0]  pin;
  logic              req_valid;
  logic [1:0]        service;
  logic [AMT_W-1:0]  amount;
  logic              anotherServiceBit;
  logic [BAL_W-1:0]  balance;
  logic              amIhere;
  logic              longTime;
  logic              done;
  logic [2:0]        err;
  logic              card_retained;
  logic              session_end;

  modport master (
    output card_valid, cardno, language, correctPin, currentbalance,
    output pin_valid, pin, req_valid, service, amount, anotherServiceBit,
    input  balance, amIhere, longTime, done, err, card_retained, session_end
  );

  modport slave (
    input  card_valid, cardno, language, correctPin, currentbalance,
    input  pin_valid, pin, req_valid, service, amount, anotherServiceBit,
    output balance, amIhere, longTime, done, err, card_retained, session_end
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session controller: card check, PIN retry, transaction chain, idle timeout
// Owns one session from card insertion to eject and reports the commit balance on session_end.
module atm_session_ctrl #(
  parameter int CARD_W    = 8,
  parameter int PIN_W     = 4,
  parameter int BAL_W     = 8,
  parameter int AMT_W     = 5,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 16,
  parameter int MAX_TXN   = 4
) (
  input logic              clk,
  input logic              rst,
  atm_session_ctrl_if.slave bus
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TXN_W = $clog2(MAX_TXN + 1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [TXN_W-1:0] TXN_LIMIT = TXN_W'(MAX_TXN);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, AUTH, MENU, EXEC} state_t;

  state_t             state_q, state_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic [PIN_W-1:0]   pin_q, pin_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [TXN_W-1:0]   txn_q, txn_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [1:0]         svc_q, svc_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic               another_q, another_d;
  logic               done_q, done_d;
  logic [2:0]         err_q, err_d;
  logic               long_q, long_d;
  logic               retain_q, retain_d;
  logic               send_q, send_d;

  logic [BAL_W:0]     sum;
  logic [BAL_W-1:0]   amt_ext;
  logic [TRY_W-1:0]   tries_inc;
  logic [TXN_W-1:0]   txn_inc;

  // Deposit is evaluated one bit wider so overflow is detected instead of wrapping.
  assign sum       = {1'b0, bal_q} + (BAL_W + 1)'(amt_q);
  assign amt_ext   = BAL_W'(amt_q);
  assign tries_inc = tries_q + TRY_W'(1);
  assign txn_inc   = txn_q + TXN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bal_q     <= '0;
      pin_q     <= '0;
      tries_q   <= '0;
      txn_q     <= '0;
      tmr_q     <= '0;
      svc_q     <= '0;
      amt_q     <= '0;
      another_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 3'd0;
      long_q    <= 1'b0;
      retain_q  <= 1'b0;
      send_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bal_q     <= bal_d;
      pin_q     <= pin_d;
      tries_q   <= tries_d;
      txn_q     <= txn_d;
      tmr_q     <= tmr_d;
      svc_q     <= svc_d;
      amt_q     <= amt_d;
      another_q <= another_d;
      done_q    <= done_d;
      err_q     <= err_d;
      long_q    <= long_d;
      retain_q  <= retain_d;
      send_q    <= send_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    pin_d     = pin_q;
    tries_d   = tries_q;
    txn_d     = txn_q;
    tmr_d     = tmr_q;
    svc_d     = svc_q;
    amt_d     = amt_q;
    another_d = another_q;
    done_d    = 1'b0;
    err_d     = err_q;
    long_d    = 1'b0;
    retain_d  = 1'b0;
    send_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.card_valid) begin
          if (bus.cardno == {CARD_W{1'b0}} || bus.language == 2'b00) begin
            done_d = 1'b1;
            err_d  = 3'd4;
          end else begin
            state_d = AUTH;
            pin_d   = bus.correctPin;
            bal_d   = bus.currentbalance;
            tries_d = '0;
            txn_d   = '0;
            tmr_d   = '0;
          end
        end
      end

      AUTH: begin
        if (bus.pin_valid) begin
          tmr_d = '0;
          if (bus.pin == pin_q) begin
            state_d = MENU;
          end else begin
            done_d  = 1'b1;
            err_d   = 3'd1;
            tries_d = tries_inc;
            if (tries_inc == TRY_LIMIT) begin
              retain_d = 1'b1;
              state_d  = IDLE;
            end
          end
        end else if (tmr_q == TMR_LAST) begin
          long_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      MENU: begin
        if (bus.req_valid) begin
          state_d   = EXEC;
          svc_d     = bus.service;
          amt_d     = bus.amount;
          another_d = bus.anotherServiceBit;
          tmr_d     = '0;
        end else if (tmr_q == TMR_LAST) begin
          long_d  = 1'b1;
          send_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      EXEC: begin
        done_d = 1'b1;
        err_d  = 3'd0;
        txn_d  = txn_inc;
        case (svc_q)
          2'b01: begin
            if (sum[BAL_W]) err_d = 3'd3;
            else            bal_d = sum[BAL_W-1:0];
          end
          2'b10: begin
            if (amt_ext > bal_q) err_d = 3'd2;
            else                 bal_d = bal_q - amt_ext;
          end
          default: err_d = 3'd0;
        endcase
        // Rejected requests still count toward the per-session transaction cap.
        if (another_q && svc_q != 2'b11 && txn_inc < TXN_LIMIT) begin
          state_d = MENU;
          tmr_d   = '0;
        end else begin
          state_d = IDLE;
          send_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.balance       = bal_q;
  assign bus.amIhere       = (state_q == MENU) || (state_q == EXEC);
  assign bus.longTime      = long_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.card_retained = retain_q;
  assign bus.session_end   = send_q;
endmodule
